// File: rtl/eth_receiver_ring.sv
// SPI Ethernet frame receiver with a NUM_BUFS-slot frame ring, MAC filtering and
// a CPU window onto the oldest pending frame.
module eth_receiver_ring #(
   parameter int          NUM_BUFS = 4,
   parameter int          BUF_AW   = 11,
   parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
   parameter int          MIN_LEN  = 14,
   parameter logic [15:0] BUF_BASE = 16'hF000,
   parameter logic [15:0] REG_BASE = 16'hFB00
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        spi_ss_n,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_d_in,
   input  logic        cpu_we,
   input  logic        cpu_oe,
   output logic [7:0]  cpu_d_out,
   output logic        cpu_d_oe,
   output logic        irq
);
   localparam int PW   = $clog2(NUM_BUFS);
   localparam int SLOT = 1 << BUF_AW;

   logic [2:0] sck_sr, ss_sr;
   logic [1:0] mosi_sr;
   logic       sck_rise, ss_fall, ss_rise;

   logic             active, dropped, ovf, mac_ok, bcast_ok;
   logic [2:0]       bit_cnt;
   logic [6:0]       shreg;
   logic [7:0]       new_byte;
   logic [BUF_AW:0]  cnt;
   logic             we;
   logic [PW+BUF_AW-1:0] waddr;
   logic [7:0]       wdata;

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      pending, pend_nxt;
   logic [7:0]       drop_cnt;
   logic             promisc, irq_en, irq_en_nxt;
   logic             commit, drop_ev, reg_hit, win_hit, ctrl_wr, rel, drop_clr;

   logic [7:0]        mem [NUM_BUFS*SLOT];
   logic [BUF_AW-1:0] len_mem [NUM_BUFS];
   logic [BUF_AW-1:0] cur_len;
   logic [7:0]        ram_q, reg_rd;
   logic              rd_vld, rd_win;
   logic [2:0]        rd_off;
   logic              unused_ok;

   // Synchronisers are left unreset so they track the pins through reset and
   // never produce a spurious edge when reset drops mid-frame.
   always_ff @(posedge clk) begin
      sck_sr  <= {sck_sr[1:0], spi_sck};
      ss_sr   <= {ss_sr[1:0], spi_ss_n};
      mosi_sr <= {mosi_sr[0], spi_mosi};
   end

   assign sck_rise = sck_sr[1] & ~sck_sr[2];
   assign ss_fall  = ~ss_sr[1] & ss_sr[2];
   assign ss_rise  = ss_sr[1] & ~ss_sr[2];
   assign new_byte = {shreg, mosi_sr[1]};

   function automatic logic [7:0] mac_byte(input logic [2:0] i);
      int k;
      k = 5 - int'(i);
      return MAC_ADDR[8*k +: 8];
   endfunction

   assign commit = active & ss_rise & ~dropped & ~ovf & (cnt >= (BUF_AW+1)'(MIN_LEN))
                   & (mac_ok | bcast_ok | promisc);
   assign drop_ev = active & ss_rise & ~commit;

   assign reg_hit  = cpu_a[15:3] == REG_BASE[15:3];
   assign win_hit  = cpu_a[15:BUF_AW] == BUF_BASE[15:BUF_AW];
   assign ctrl_wr  = cpu_we & reg_hit & (cpu_a[2:0] == 3'd1);
   assign rel      = ctrl_wr & cpu_d_in[0] & (pending != '0);
   assign drop_clr = cpu_we & reg_hit & (cpu_a[2:0] == 3'd4);

   assign pend_nxt   = pending + (PW+1)'(commit) - (PW+1)'(rel);
   assign irq_en_nxt = ctrl_wr ? cpu_d_in[2] : irq_en;
   assign unused_ok  = ^cpu_d_in[7:3];

   always_ff @(posedge clk) begin
      if (n_rst) begin
         active   <= 1'b0;
         dropped  <= 1'b0;
         ovf      <= 1'b0;
         mac_ok   <= 1'b1;
         bcast_ok <= 1'b1;
         bit_cnt  <= '0;
         shreg    <= '0;
         cnt      <= '0;
         we       <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pending  <= '0;
         drop_cnt <= '0;
         promisc  <= 1'b0;
         irq_en   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         we <= 1'b0;
         if (ss_fall) begin
            active   <= 1'b1;
            dropped  <= pending == (PW+1)'(NUM_BUFS);
            cnt      <= '0;
            bit_cnt  <= '0;
            ovf      <= 1'b0;
            mac_ok   <= 1'b1;
            bcast_ok <= 1'b1;
         end else if (ss_rise) begin
            active <= 1'b0;
         end else if (active && !dropped && sck_rise) begin
            shreg   <= new_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (!cnt[BUF_AW]) begin
                  we    <= 1'b1;
                  waddr <= {wr_ptr, cnt[BUF_AW-1:0]};
                  wdata <= new_byte;
                  cnt   <= cnt + (BUF_AW+1)'(1);
               end else begin
                  ovf <= 1'b1;
               end
               if (cnt < (BUF_AW+1)'(6)) begin
                  if (new_byte != mac_byte(cnt[2:0])) mac_ok <= 1'b0;
                  if (new_byte != 8'hFF) bcast_ok <= 1'b0;
               end
            end
         end

         if (commit) wr_ptr <= wr_ptr + PW'(1);
         if (rel) rd_ptr <= rd_ptr + PW'(1);
         pending <= pend_nxt;

         if (drop_clr) drop_cnt <= '0;
         else if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

         if (ctrl_wr) begin
            promisc <= cpu_d_in[1];
            irq_en  <= cpu_d_in[2];
         end
         irq <= irq_en_nxt & (pend_nxt != '0);
      end
   end

   // Frame storage and lengths are not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      ram_q <= mem[{rd_ptr, cpu_a[BUF_AW-1:0]}];
      if (commit) len_mem[wr_ptr] <= cnt[BUF_AW-1:0];
   end

   assign cur_len = len_mem[rd_ptr];

   always_comb begin
      reg_rd = 8'h00;
      case (rd_off)
         3'd0:    reg_rd = {3'b000, 5'(pending)};
         3'd1:    reg_rd = {5'b00000, irq_en, promisc, 1'b0};
         3'd2:    reg_rd = cur_len[7:0];
         3'd3:    reg_rd = 8'(cur_len >> 8);
         3'd4:    reg_rd = drop_cnt;
         default: reg_rd = 8'h00;
      endcase
   end

   // Two-stage read: request/RAM fetch at the oe edge, data out on the next.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         rd_vld    <= 1'b0;
         rd_win    <= 1'b0;
         rd_off    <= '0;
         cpu_d_out <= '0;
         cpu_d_oe  <= 1'b0;
      end else begin
         rd_vld    <= cpu_oe & (reg_hit | win_hit);
         rd_win    <= win_hit;
         rd_off    <= cpu_a[2:0];
         cpu_d_oe  <= rd_vld;
         cpu_d_out <= !rd_vld ? 8'h00 : (rd_win ? ram_q : reg_rd);
      end
   end
endmodule

// File: doc/eth_receiver_ring.md
# eth_receiver_ring

Multi-slot successor to the single-buffer SPI Ethernet frame receiver. It deserialises frames pushed by the Ethernet front-end over SPI and filters them on destination MAC. Accepted frames go into a ring of NUM_BUFS frame slots, so the CPU can drain one frame while later frames keep arriving. It sits on the CPU memory bus as a data window onto the oldest pending frame plus a small register block, and raises an interrupt while frames are pending.

## Interface
- NUM_BUFS, 4: number of frame slots; power of two, 2..16.
- BUF_AW, 11: slot address width; each slot holds 2^BUF_AW bytes.
- MAC_ADDR, 48'h02_00_00_00_00_01: station address; byte 0 is the first byte on the wire, held in bits [47:40].
- MIN_LEN, 14: minimum accepted frame length in bytes.
- BUF_BASE, 16'hF000: base of the 2^BUF_AW-byte data window; must be aligned to 2^BUF_AW.
- REG_BASE, 16'hFB00: base of the 8-byte register block.
- clk  in  1  system clock; all logic is on the rising edge.
- n_rst  in  1  reset, synchronous, active-high.
- spi_sck  in  1  SPI clock, asynchronous.
- spi_mosi  in  1  SPI data, asynchronous.
- spi_ss_n  in  1  SPI frame select, asynchronous, active low.
- cpu_a  in  16  CPU address.
- cpu_d_in  in  8  CPU write data.
- cpu_we  in  1  write strobe, one clk per access.
- cpu_oe  in  1  read strobe.
- cpu_d_out  out  8  registered read data.
- cpu_d_oe  out  1  drive enable for cpu_d_out.
- irq  out  1  pending-frame interrupt.

## Operation
- SPI inputs pass through 2-flop synchronisers, followed by edge detection. The SPI link is mode 0, MSB first: mosi is sampled on sck rise.
- Falling ss begins a frame:
  - byte count cnt=0;
  - flags ovf=0, mac_ok=1, bcast_ok=1.
  - If the ring is full (pending==NUM_BUFS), the frame is marked dropped and every byte of it is ignored.
- On each completed byte:
  - If cnt < 2^BUF_AW: write the byte to slot[wr_ptr] at offset cnt.
  - Otherwise: set ovf.
  - For cnt<6: clear mac_ok if the byte differs from the MAC_ADDR byte; clear bcast_ok if the byte differs from 8'hFF.
  - cnt increments and saturates at 2^BUF_AW.
- Rising ss ends a frame. Partial trailing bits are discarded.
  - Commit condition: not dropped, ovf=0, cnt>=MIN_LEN, and (mac_ok | bcast_ok | promisc).
  - On commit: len[wr_ptr]=cnt, wr_ptr++ (mod NUM_BUFS), pending++.
  - Otherwise: drop_cnt++, saturating at 255. A full-ring drop counts as one drop per frame.
- Registers (offsets from REG_BASE):
  - 0 R: status = {3'b0, pending[4:0]}.
  - 1 R/W: control.
    - Bit 0 (release): write-1 pops the head slot (rd_ptr++, pending--); ignored when pending==0; reads as 0.
    - Bit 1: promisc.
    - Bit 2: irq_en.
  - 2 R: len_lo = len[rd_ptr][7:0].
  - 3 R: len_hi = len[rd_ptr][BUF_AW-1:8], zero-extended.
  - 4 R: drop_cnt; any write clears it.
  - 5-7: read 0.
- Data window: a read at BUF_BASE+off returns slot[rd_ptr][off]. Content is undefined when pending==0. CPU writes to the window are ignored.
- irq = irq_en & (pending!=0).
- The buffer RAM has two ports: receive write and CPU read. The same address may be hit on both ports in one cycle only for a slot that is not pending; that read returns undefined data.
- Commit and release in the same clk: both pointers advance and pending is unchanged.
- Reset forces:
  - wr_ptr, rd_ptr, pending, drop_cnt, control = 0;
  - any frame in progress is aborted;
  - the receiver waits for the next ss fall;
  - cpu_d_out=0, cpu_d_oe=0, irq=0.
  - RAM contents are not cleared.

## Timing
- clk must be at least 4x spi_sck frequency.
- SPI pin edge to internal edge-detect pulse: 2-3 clk.
- Byte write to RAM occurs 1 clk after the 8th sck-rise pulse.
- Commit: pending, status and irq update on the clk edge after the internal ss-rise pulse, i.e. 3-4 clk after the pin edge.
- CPU read: cpu_oe sampled at edge k; cpu_d_out and cpu_d_oe are valid after edge k+1 and held for one clk. cpu_d_oe is low in every other cycle and for addresses outside both windows.
- CPU write: takes effect at the sampling edge. A read of status in the next cycle reflects the release.

## Test plan
- Reset mid-frame, with n_rst=1 for 2 clk during byte 3 → status=0, irq=0, drop_cnt=0. The next full 64-byte frame to MAC_ADDR commits in slot 0 with len=64.
- 60-byte frame to MAC_ADDR, irq_en=1 → status=1, irq=1, len_lo=60, len_hi=0, window bytes match the stimulus. Write control=0x05 → status=0, irq=0.
- Frames addressed to FF:FF:FF:FF:FF:FF, to a foreign MAC, and to a foreign MAC with promisc=1 → first and third commit; drop_cnt=1.
- NUM_BUFS+1 frames sent without release → status=NUM_BUFS, drop_cnt=1. After releases, slots read back in arrival order, including across the wr_ptr wrap.
- Frame of 13 bytes, frame of 2^BUF_AW+1 bytes, and a frame ending with 5 stray bits after byte 20 → drop, drop, commit with len=20.
- Release written in the same clk as a commit, with status=2 → status stays 2 and rd_ptr advances.
